// File: rtl/led_pkg.sv
// led_pkg
// Shared constants for the LED PWM driver: register word addresses, CTRL bit
// positions, register reset values and the PWM compare helper used by every
// channel.
// No ports (package).

package led_pkg;

  // Register word addresses
  localparam logic [7:0] ADDR_CTRL       = 8'h00;
  localparam logic [7:0] ADDR_BLINK_MASK = 8'h01;
  localparam logic [7:0] ADDR_BLINK_HALF = 8'h02;
  localparam logic [7:0] ADDR_PRESCALE   = 8'h03;
  localparam logic [7:0] ADDR_DUTY_BASE  = 8'h08;

  // CTRL bit positions
  localparam int EN_BIT  = 0;
  localparam int INV_BIT = 1;

  // Register reset values
  localparam logic [1:0]  CTRL_RESET       = 2'b01;
  localparam logic [31:0] BLINK_HALF_RESET = 32'h0000_00FF;
  localparam logic [7:0]  PRESCALE_RESET   = 8'h00;
  localparam logic [7:0]  DUTY_RESET       = 8'hFF;

  // A duty of 0xFF is treated as "fully on" so a channel can reach 100%
  // brightness even though the 8-bit counter never exceeds 255.
  localparam logic [7:0] DUTY_FULL = 8'hFF;

  function automatic logic pwm_compare(input logic [7:0] cnt,
                                       input logic [7:0] duty);
    return (duty == DUTY_FULL) || (cnt < duty);
  endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// led_pwm_channel
// One LED output bit: combines the pattern bit, PWM compare, blink gating and
// global enable, then registers the pin with optional inversion.
// Ports:
//   clk      - system clock
//   rst_n    - synchronous active-low reset (pin forced to 0)
//   pwm_cnt  - shared 8-bit PWM counter
//   duty     - this channel's duty value
//   led_in   - this channel's pattern bit
//   blink_en - this channel's blink mask bit
//   phase    - shared blink phase (1 = on half)
//   en       - global enable
//   inv      - global pin inversion
//   pin      - registered pin drive

module led_pwm_channel
  import led_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pwm_cnt,
  input  logic [7:0] duty,
  input  logic       led_in,
  input  logic       blink_en,
  input  logic       phase,
  input  logic       en,
  input  logic       inv,
  output logic       pin
);

  logic raw;

  // A masked channel is only lit during the on-half of the blink phase.
  always_comb begin
    raw = en & led_in & pwm_compare(pwm_cnt, duty) & (~blink_en | phase);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pin <= 1'b0;
    end else begin
      pin <= raw ^ inv;
    end
  end

endmodule

// File: rtl/led_pwm_driver.sv
// led_pwm_driver
// Drives the physical LED pins from the LED register block's pattern, adding
// per-LED PWM brightness and a masked blink with programmable half-period.
// Configured over a zero-wait-state Avalon-MM slave.
// Ports:
//   CLK     - system clock
//   RST     - synchronous active-low reset
//   WRITE   - Avalon write strobe
//   READ    - Avalon read strobe
//   ADDR    - word address
//   WDATA   - write data
//   RDATA   - registered read data (valid the cycle after READ)
//   LED_IN  - LED pattern from the LED register block
//   LED_OUT - registered pin drive

module led_pwm_driver
  import led_pkg::*;
#(
  parameter int N_LEDS  = 8,
  parameter int BLINK_W = 24
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WRITE,
  input  logic              READ,
  input  logic [7:0]        ADDR,
  input  logic [31:0]       WDATA,
  output logic [31:0]       RDATA,
  input  logic [N_LEDS-1:0] LED_IN,
  output logic [N_LEDS-1:0] LED_OUT
);

  // Configuration registers
  logic               ctrl_en;
  logic               ctrl_inv;
  logic [N_LEDS-1:0]  blink_mask;
  logic [BLINK_W-1:0] blink_half;
  logic [7:0]         prescale;
  logic [7:0]         duty [N_LEDS];

  // Timebase
  logic [7:0]         presc_cnt;
  logic [7:0]         pwm_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic               phase;
  logic               tick;
  logic               period_wrap;

  logic [31:0]        rd_mux;

  // Upper write-data bits have no register behind them.
  logic               unused_wdata;
  assign unused_wdata = ^WDATA;

  // Register file writes; unmapped addresses fall through untouched.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      ctrl_en    <= CTRL_RESET[EN_BIT];
      ctrl_inv   <= CTRL_RESET[INV_BIT];
      blink_mask <= '0;
      blink_half <= BLINK_HALF_RESET[BLINK_W-1:0];
      prescale   <= PRESCALE_RESET;
      for (int i = 0; i < N_LEDS; i++) begin
        duty[i] <= DUTY_RESET;
      end
    end else if (WRITE) begin
      case (ADDR)
        ADDR_CTRL: begin
          ctrl_en  <= WDATA[EN_BIT];
          ctrl_inv <= WDATA[INV_BIT];
        end
        ADDR_BLINK_MASK: blink_mask <= WDATA[N_LEDS-1:0];
        ADDR_BLINK_HALF: blink_half <= WDATA[BLINK_W-1:0];
        ADDR_PRESCALE:   prescale   <= WDATA[7:0];
        default: ;
      endcase
      for (int i = 0; i < N_LEDS; i++) begin
        if (ADDR == ADDR_DUTY_BASE + 8'(i)) begin
          duty[i] <= WDATA[7:0];
        end
      end
    end
  end

  // Read mux sees the registers before any same-cycle write lands.
  always_comb begin
    rd_mux = '0;
    case (ADDR)
      ADDR_CTRL: begin
        rd_mux[EN_BIT]  = ctrl_en;
        rd_mux[INV_BIT] = ctrl_inv;
      end
      ADDR_BLINK_MASK: rd_mux[N_LEDS-1:0]  = blink_mask;
      ADDR_BLINK_HALF: rd_mux[BLINK_W-1:0] = blink_half;
      ADDR_PRESCALE:   rd_mux[7:0]         = prescale;
      default: ;
    endcase
    for (int i = 0; i < N_LEDS; i++) begin
      if (ADDR == ADDR_DUTY_BASE + 8'(i)) begin
        rd_mux[7:0] = duty[i];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      RDATA <= '0;
    end else if (READ) begin
      RDATA <= rd_mux;
    end
  end

  // Using >= lets a lowered PRESCALE take effect on the next cycle instead
  // of waiting for the counter to wrap through 255.
  assign tick        = ctrl_en && (presc_cnt >= prescale);
  assign period_wrap = tick && (pwm_cnt == 8'hFF);

  // Prescaler, PWM counter and blink counter. Disabling parks everything at
  // its start point so re-enabling begins a fresh PWM period in the on phase.
  always_ff @(posedge CLK) begin
    if (!RST || !ctrl_en) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else begin
      if (tick) begin
        presc_cnt <= '0;
        pwm_cnt   <= pwm_cnt + 8'd1;
      end else begin
        presc_cnt <= presc_cnt + 8'd1;
      end
      if (period_wrap) begin
        if (blink_cnt >= blink_half) begin
          blink_cnt <= '0;
          phase     <= ~phase;
        end else begin
          blink_cnt <= blink_cnt + BLINK_W'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < N_LEDS; g++) begin : g_chan
    led_pwm_channel u_chan (
      .clk      (CLK),
      .rst_n    (RST),
      .pwm_cnt  (pwm_cnt),
      .duty     (duty[g]),
      .led_in   (LED_IN[g]),
      .blink_en (blink_mask[g]),
      .phase    (phase),
      .en       (ctrl_en),
      .inv      (ctrl_inv),
      .pin      (LED_OUT[g])
    );
  end

endmodule

// File: tb/tb_led_pwm_driver.sv
// tb_led_pwm_driver
// Directed bench for led_pwm_driver: register access, PWM duty, blink,
// inversion/enable, prescaler retiming and mid-blink reset.
// No ports.

module tb_led_pwm_driver;

  localparam int N_LEDS  = 8;
  localparam int BLINK_W = 24;

  logic              clk = 1'b0;
  logic              rst;
  logic              write;
  logic              read;
  logic [7:0]        addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic [N_LEDS-1:0] led_in;
  logic [N_LEDS-1:0] led_out;

  int n_compared   = 0;
  int n_mismatched = 0;

  led_pwm_driver #(.N_LEDS(N_LEDS), .BLINK_W(BLINK_W)) dut (
    .CLK     (clk),
    .RST     (rst),
    .WRITE   (write),
    .READ    (read),
    .ADDR    (addr),
    .WDATA   (wdata),
    .RDATA   (rdata),
    .LED_IN  (led_in),
    .LED_OUT (led_out)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle just after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    write = 1'b1;
    addr  = a;
    wdata = d;
    step(1);
    write = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    read = 1'b1;
    addr = a;
    step(1);
    read = 1'b0;
    d    = rdata;
  endtask

  task automatic bus_write_read(input logic [7:0] a, input logic [31:0] d,
                                output logic [31:0] q);
    write = 1'b1;
    read  = 1'b1;
    addr  = a;
    wdata = d;
    step(1);
    write = 1'b0;
    read  = 1'b0;
    q     = rdata;
  endtask

  // Count how many of the next n samples have LED_OUT[bit_idx] high.
  task automatic count_high(input int bit_idx, input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      step(1);
      if (led_out[bit_idx]) cnt++;
    end
  endtask

  initial begin
    logic [31:0] rd;
    int          cnt;
    int          cnt0;
    int          cnt1a;
    int          cnt1b;

    rst    = 1'b0;
    write  = 1'b0;
    read   = 1'b0;
    addr   = '0;
    wdata  = '0;
    led_in = '0;

    // Reset and default pass-through
    step(3);
    check_output("reset_led_out", 32'(led_out), 32'h0);
    check_output("reset_rdata", rdata, 32'h0);
    rst    = 1'b1;
    led_in = 8'h5A;
    step(1);
    check_output("passthru_5a", 32'(led_out), 32'h5A);
    led_in = 8'hA5;
    step(1);
    check_output("passthru_a5", 32'(led_out), 32'hA5);

    // Register defaults
    bus_read(8'h00, rd); check_output("rd_ctrl_default", rd, 32'h1);
    step(1);             check_output("rdata_hold", rdata, 32'h1);
    bus_read(8'h08, rd); check_output("rd_duty0_default", rd, 32'hFF);
    bus_read(8'h02, rd); check_output("rd_blink_half_default", rd, 32'hFF);
    bus_read(8'h03, rd); check_output("rd_prescale_default", rd, 32'h0);
    bus_read(8'h01, rd); check_output("rd_blink_mask_default", rd, 32'h0);
    bus_read(8'h55, rd); check_output("rd_unmapped", rd, 32'h0);

    // Simultaneous write and read returns the old value
    bus_write_read(8'h03, 32'h5, rd); check_output("wr_rd_same_cycle", rd, 32'h0);
    bus_read(8'h03, rd);              check_output("rd_after_write", rd, 32'h5);
    bus_write(8'h03, 32'h0);

    // PWM duty: 64/256
    led_in = 8'h01;
    bus_write(8'h08, 32'h40);
    step(2);
    count_high(0, 256, cnt); check_output("duty40_on_count", 32'(cnt), 32'd64);
    check_output("duty40_other_bits", 32'(led_out & 8'hFE), 32'h0);
    bus_write(8'h08, 32'hFE);
    step(2);
    count_high(0, 256, cnt); check_output("dutyFE_on_count", 32'(cnt), 32'd254);
    bus_write(8'h08, 32'h00);
    step(2);
    count_high(0, 256, cnt); check_output("duty00_on_count", 32'(cnt), 32'd0);
    bus_write(8'h08, 32'hFF);
    step(2);
    count_high(0, 256, cnt); check_output("dutyFF_on_count", 32'(cnt), 32'd256);

    // Blink: mask LED1, half-period of 2 PWM periods (512 clocks)
    led_in = 8'h03;
    bus_write(8'h02, 32'h1);
    bus_write(8'h01, 32'h2);
    bus_write(8'h00, 32'h0);
    step(2);
    check_output("disabled_off", 32'(led_out), 32'h0);
    bus_write(8'h00, 32'h1);
    cnt0  = 0;
    cnt1a = 0;
    cnt1b = 0;
    for (int k = 1; k <= 1024; k++) begin
      step(1);
      if (led_out[0]) cnt0++;
      if (led_out[1] && k <= 512) cnt1a++;
      if (led_out[1] && k > 512) cnt1b++;
    end
    check_output("blink_on_half", 32'(cnt1a), 32'd512);
    check_output("blink_off_half", 32'(cnt1b), 32'd0);
    check_output("unmasked_steady", 32'(cnt0), 32'd1024);
    step(1);
    check_output("blink_on_again", 32'(led_out), 32'h3);

    // Inversion and disable
    bus_write(8'h01, 32'h0);
    led_in = 8'hFF;
    bus_write(8'h00, 32'h3);
    step(1);
    check_output("inv_enabled", 32'(led_out), 32'h00);
    bus_write(8'h00, 32'h2);
    step(1);
    check_output("inv_disabled", 32'(led_out), 32'hFF);
    step(5);
    check_output("held_pwm_cnt", 32'(dut.pwm_cnt), 32'h0);
    check_output("held_presc_cnt", 32'(dut.presc_cnt), 32'h0);
    check_output("held_led_out", 32'(led_out), 32'hFF);
    bus_read(8'h00, rd); check_output("rd_ctrl_inv", rd, 32'h2);

    // Lowering PRESCALE mid-count ticks on the next cycle
    bus_write(8'h03, 32'd200);
    bus_write(8'h00, 32'h1);
    step(100);
    check_output("presc_at_100", 32'(dut.presc_cnt), 32'd100);
    check_output("no_tick_at_100", 32'(dut.tick), 32'h0);
    bus_write(8'h03, 32'd10);
    check_output("tick_after_lower", 32'(dut.tick), 32'h1);
    for (int k = 1; k <= 22; k++) begin
      step(1);
      check_output($sformatf("tick_k%0d", k), 32'(dut.tick),
                   (k == 11 || k == 22) ? 32'h1 : 32'h0);
    end
    bus_write(8'h03, 32'h0);

    // Reset while blink is in its off phase
    led_in = 8'h03;
    bus_write(8'h02, 32'h0);
    bus_write(8'h01, 32'h2);
    bus_write(8'h00, 32'h0);
    step(1);
    bus_write(8'h00, 32'h1);
    step(257);
    check_output("phase_off_before_reset", 32'(dut.phase), 32'h0);
    check_output("led_blink_off", 32'(led_out), 32'h1);
    bus_write(8'h0B, 32'h10);
    bus_read(8'h0B, rd); check_output("rd_duty3", rd, 32'h10);
    rst = 1'b0;
    step(1);
    check_output("rst_led_out", 32'(led_out), 32'h0);
    check_output("rst_rdata", rdata, 32'h0);
    check_output("rst_phase", 32'(dut.phase), 32'h1);
    check_output("rst_pwm_cnt", 32'(dut.pwm_cnt), 32'h0);
    rst = 1'b1;
    bus_read(8'h00, rd); check_output("post_rst_ctrl", rd, 32'h1);
    bus_read(8'h01, rd); check_output("post_rst_mask", rd, 32'h0);
    bus_read(8'h02, rd); check_output("post_rst_half", rd, 32'hFF);
    bus_read(8'h03, rd); check_output("post_rst_prescale", rd, 32'h0);
    bus_read(8'h0B, rd); check_output("post_rst_duty3", rd, 32'hFF);
    bus_write(8'h55, 32'h1234);
    bus_read(8'h55, rd); check_output("post_rst_unmapped", rd, 32'h0);
    bus_read(8'h0F, rd); check_output("post_rst_duty7", rd, 32'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/led_pwm_driver.md
Name: led_pwm_driver

Overview:
- Downstream stage of the LED register block: consumes its 8-bit LED pattern and drives the physical LED pins.
- Adds per-LED 8-bit PWM brightness and a per-LED blink mask with a programmable blink rate.
- Configured over the same Avalon-MM slave style as the LED register (WRITE/READ/ADDR/WDATA/RDATA, zero wait states).

Parameters:
- N_LEDS, 8, number of LED channels (1..8); pattern and output width.
- BLINK_W, 24, width of the blink half-period register and counter.

Ports:
- CLK  in  1  system clock; single clock domain.
- RST  in  1  reset: synchronous, active-low (sampled on CLK rising edge, 0 = reset).
- WRITE  in  1  Avalon write strobe, single cycle, no waitrequest.
- READ  in  1  Avalon read strobe.
- ADDR  in  8  word address.
- WDATA  in  32  write data.
- RDATA  out  32  read data, registered.
- LED_IN  in  N_LEDS  LED pattern from the LED register block.
- LED_OUT  out  N_LEDS  registered pin drive.

Behaviour:
- Register map (word addresses; unmapped writes ignored, unmapped reads return 0):
  - 0x00 CTRL: bit0 EN, bit1 INV (active-low pins). Reset 0x1.
  - 0x01 BLINK_MASK [N_LEDS-1:0]. Reset 0.
  - 0x02 BLINK_HALF [BLINK_W-1:0], in PWM periods. Reset 0x0000FF.
  - 0x03 PRESCALE [7:0]. Reset 0.
  - 0x08+i DUTY[i] [7:0], for i < N_LEDS. Reset 0xFF.
- Register updates:
  - A write lands on the CLK edge where WRITE=1.
  - If WRITE and READ are both high in the same cycle, both occur; RDATA returns the pre-write value.
- Read path:
  - RDATA is valid the cycle after READ=1.
  - RDATA holds its last value otherwise.
  - RDATA resets to 0.
- Prescaler: 8-bit presc_cnt.
  - tick=1 when presc_cnt >= PRESCALE; presc_cnt then clears, otherwise it increments.
  - Using >= means that lowering PRESCALE mid-count ticks on the next cycle and never runs away.
- PWM counter: 8-bit pwm_cnt increments on tick and wraps 255->0. One PWM period = 256*(PRESCALE+1) clocks.
- pwm_on[i]:
  - 1 if DUTY[i]==0xFF.
  - Otherwise 1 when pwm_cnt < DUTY[i].
  - DUTY 0 gives always off.
- Blink:
  - On tick with pwm_cnt==255 (period wrap), blink_cnt increments.
  - If blink_cnt >= BLINK_HALF at that wrap, blink_cnt clears and phase toggles.
  - BLINK_HALF=0 toggles phase every PWM period.
  - phase resets to 1 (on).
- Output, registered with 1-cycle latency:
  - raw[i] = EN & LED_IN[i] & pwm_on[i] & (~BLINK_MASK[i] | phase).
  - LED_OUT[i] = raw[i] ^ INV.
- EN=0:
  - presc_cnt, pwm_cnt and blink_cnt are held at 0, and phase is held at 1.
  - Outputs are all off: LED_OUT = {N_LEDS{INV}}.
  - On re-enable, the first PWM period starts at pwm_cnt=0.
- Reset (RST=0):
  - Takes effect at any time, including mid-period or mid-blink.
  - All registers and counters return to their reset values.
  - LED_OUT=0 and RDATA=0 on the following edge.
- Post-reset defaults (EN=1, duty full, no blink): LED_OUT equals LED_IN delayed by one cycle.

Decomposition:
- Shared package led_pkg:
  - Address constants ADDR_CTRL, ADDR_BLINK_MASK, ADDR_BLINK_HALF, ADDR_PRESCALE, ADDR_DUTY_BASE.
  - CTRL bit indices EN_BIT, INV_BIT.
  - Reset-value constants.
- Sub-module led_pwm_channel: one per LED, instantiated N_LEDS times.
  - Inputs: pwm_cnt, duty, led_in, blink_en, phase, en, inv.
  - Output: registered pin bit.
- The top level holds the register file, prescaler, PWM counter and blink counter.

Test Plan:
- Reset then LED_IN=0x5A -> LED_OUT=0x5A one cycle later; read ADDR 0x00 -> RDATA=0x1; read 0x08 -> 0xFF.
- PRESCALE=0, DUTY[0]=0x40, LED_IN=0x01 -> LED_OUT[0] high 64 of every 256 clocks. Then DUTY[0]=0 -> constant low.
- BLINK_MASK=0x02, BLINK_HALF=1, PRESCALE=0, LED_IN=0x03:
  - LED_OUT[1] alternates 512 clocks on / 512 off.
  - LED_OUT[0] stays steady high.
- CTRL=0x3 (EN, INV), LED_IN=0xFF, duty full -> LED_OUT=0x00. Then CTRL=0x2 -> LED_OUT=0xFF and counters held at 0.
- PRESCALE=200 with presc_cnt at 100, write PRESCALE=10 -> tick on the next cycle; subsequent ticks every 11 clocks.
- Assert RST=0 mid-blink (phase=0) -> next edge: LED_OUT=0, RDATA=0, all registers at reset values. Read ADDR 0x55 -> RDATA=0.
